alu_seq_unit: RTL and testbench

- Parametrised, multi-cycle ALU execution unit; successor to the fixed 16-bit ALU-control/flag definitions.
- Accepts one operation per transaction, decoded as a one-hot control vector, over a valid/ready handshake.
- Single-cycle ops take one cycle; MUL/DIV/MOD run iteratively for WIDTH cycles.
- Holds persistent compare flags (GT, ET) and sits between the decode stage and writeback.

---
 rtl/alu_seq_unit.sv | 208 ++++++++++++++++++++
 tb/tb_alu_seq_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : alu_seq_unit
// Purpose  : Parametrised multi-cycle ALU execution unit. Takes one-hot
//            encoded operations over a valid/ready handshake. Single-cycle
//            ops finish in one cycle. MUL/DIV/MOD iterate bit-serially.
//            Holds persistent compare flags (GT, ET).
// Ports    : clk, rst          - clock (rising edge), sync active-high reset
//            in_valid/in_ready - operation handshake (in_ready = idle)
//            op[12:0]          - one-hot: Add,Sub,Cmp,Mul,Div,Mod,Lsl,Lsr,
//                                Asr,Or,And,Not,Mov (bit 0 .. bit 12)
//            op_a, op_b        - operands
//            out_valid/out_ready - result handshake
//            result, err       - registered result; err = div-by-zero or
//                                illegal op (qualified by out_valid)
//            flag_gt, flag_et  - persistent compare flags, written by Cmp
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
  parameter int WIDTH      = 16,
  parameter bit SIGNED_CMP = 1'b0,
  parameter int SHW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [12:0]      op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             flag_gt,
  output logic             flag_et
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             err_q;
  logic             flag_gt_q;
  logic             flag_et_q;

  // Iterative datapath. a_q is the multiplicand (MUL) or the dividend that
  // shifts out MSB-first while the quotient shifts in (DIV/MOD). acc_q is the
  // partial product (MUL) or the partial remainder (DIV/MOD).
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [SHW-1:0]   cnt_q;
  logic             is_mul_q;
  logic             is_div_q;
  logic             dz_q;

  // Decode / single-cycle datapath
  logic             w_onehot;
  logic             w_is_iter;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sc_result;
  logic             w_gt;
  logic             w_et;

  // One iteration step
  logic [WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]   w_trial;
  logic             w_ge;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_iter_result;

  always_comb begin
    w_onehot    = (op != 13'd0) && ((op & (op - 13'd1)) == 13'd0);
    w_is_iter   = w_onehot && (op[3] || op[4] || op[5]);
    w_shamt     = op_b[SHW-1:0];
    w_et        = (op_a == op_b);
    w_gt        = SIGNED_CMP ? ($signed(op_a) > $signed(op_b)) : (op_a > op_b);
    w_sc_result = '0;
    if (w_onehot) begin
      case (1'b1)
        op[0]:   w_sc_result = op_a + op_b;
        op[1]:   w_sc_result = op_a - op_b;
        op[2]:   w_sc_result = op_a - op_b;
        op[6]:   w_sc_result = op_a << w_shamt;
        op[7]:   w_sc_result = op_a >> w_shamt;
        op[8]:   w_sc_result = WIDTH'($signed(op_a) >>> w_shamt);
        op[9]:   w_sc_result = op_a | op_b;
        op[10]:  w_sc_result = op_a & op_b;
        op[11]:  w_sc_result = ~op_a;
        op[12]:  w_sc_result = op_b;
        default: w_sc_result = '0;
      endcase
    end
  end

  always_comb begin
    w_mul_next = acc_q + (b_q[0] ? a_q : '0);
    w_trial    = {acc_q, a_q[WIDTH-1]};
    w_ge       = (w_trial >= {1'b0, b_q});
    // When w_ge holds the difference is below b_q, so the low WIDTH bits
    // carry the full remainder.
    w_sub      = w_trial[WIDTH-1:0] - b_q;
    w_rem_next = w_ge ? w_sub : w_trial[WIDTH-1:0];
    w_quo_next = {a_q[WIDTH-2:0], w_ge};
    if (is_mul_q) begin
      w_iter_result = w_mul_next;
    end else if (is_div_q) begin
      w_iter_result = w_quo_next;
    end else begin
      w_iter_result = w_rem_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      flag_gt_q   <= 1'b0;
      flag_et_q   <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      is_mul_q    <= 1'b0;
      is_div_q    <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (w_is_iter) begin
              state_q  <= S_ITER;
              a_q      <= op_a;
              b_q      <= op_b;
              acc_q    <= '0;
              cnt_q    <= SHW'(WIDTH - 1);
              is_mul_q <= op[3];
              is_div_q <= op[4];
              dz_q     <= (op_b == '0) && !op[3];
            end else begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= w_sc_result;
              err_q       <= !w_onehot;
              if (w_onehot && op[2]) begin
                flag_gt_q <= w_gt;
                flag_et_q <= w_et;
              end
            end
          end
        end
        S_ITER: begin
          if (is_mul_q) begin
            acc_q <= w_mul_next;
            a_q   <= a_q << 1;
            b_q   <= b_q >> 1;
          end else begin
            acc_q <= w_rem_next;
            a_q   <= w_quo_next;
          end
          cnt_q <= cnt_q - 1'b1;
          // The last step's outcome is captured directly into result_q.
          if (cnt_q == '0) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= w_iter_result;
            err_q       <= dz_q;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign err       = err_q;
  assign flag_gt   = flag_gt_q;
  assign flag_et   = flag_et_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq_unit
// Purpose  : Self-checking bench for alu_seq_unit (WIDTH=16). Two instances
//            share all inputs: one with unsigned compare, one with signed
//            compare. Expected results are queued when an op is driven and
//            popped when the result handshake completes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

  localparam int W = 16;
  localparam logic [12:0] ADD = 13'h0001, SUB = 13'h0002, CMP = 13'h0004,
                          MUL = 13'h0008, DIV = 13'h0010, MOD = 13'h0020,
                          LSL = 13'h0040, LSR = 13'h0080, ASR = 13'h0100,
                          OR_ = 13'h0200, AND = 13'h0400, NOT = 13'h0800,
                          MOV = 13'h1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [12:0]   op;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          err;
  logic          flag_gt;
  logic          flag_et;

  logic          s_in_ready;
  logic          s_out_valid;
  logic [W-1:0]  s_result;
  logic          s_err;
  logic          s_flag_gt;
  logic          s_flag_et;

  alu_seq_unit #(.WIDTH(W), .SIGNED_CMP(1'b0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .err(err), .flag_gt(flag_gt), .flag_et(flag_et)
  );

  alu_seq_unit #(.WIDTH(W), .SIGNED_CMP(1'b1)) u_dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .op(op),
    .op_a(op_a), .op_b(op_b), .out_valid(s_out_valid), .out_ready(out_ready),
    .result(s_result), .err(s_err), .flag_gt(s_flag_gt), .flag_et(s_flag_et)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    string        tag;
    logic [W-1:0] res;
    logic         err;
    int           lat;
    int           acc_cyc;
    logic         gt, et, sgt, set;
  } exp_t;

  exp_t sb[$];

  // Bench-side flag models for both compare flavours
  logic m_gt = 1'b0, m_et = 1'b0, m_sgt = 1'b0, m_set = 1'b0;

  function automatic logic [W-1:0] ref_res(input logic [12:0] o, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (o)
      ADD:     return a + b;
      SUB:     return a - b;
      MUL:     return p[W-1:0];
      DIV:     return (b == 0) ? {W{1'b1}} : a / b;
      MOD:     return (b == 0) ? a : a % b;
      default: return '0;
    endcase
  endfunction

  // Scoreboard monitor: latency on first out_valid, payload on handshake
  bit lat_seen = 0;
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        if (!lat_seen) begin
          lat_seen = 1;
          chk({sb[0].tag, "_latency"}, 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
        end
        if (out_ready) begin
          exp_t e;
          e = sb.pop_front();
          lat_seen = 0;
          chk({e.tag, "_result"}, 32'(result), 32'(e.res));
          chk({e.tag, "_err"}, 32'(err), 32'(e.err));
          chk({e.tag, "_gt"}, 32'(flag_gt), 32'(e.gt));
          chk({e.tag, "_et"}, 32'(flag_et), 32'(e.et));
          chk({e.tag, "_sgt"}, 32'(s_flag_gt), 32'(e.sgt));
          chk({e.tag, "_set"}, 32'(s_flag_et), 32'(e.set));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [12:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ee,
                        input int hold);
    exp_t e;
    int   n;
    wait_ready();
    if (hold > 0) out_ready = 1'b0;
    in_valid = 1'b1;
    op       = o;
    op_a     = a;
    op_b     = b;
    if (o == CMP) begin
      m_gt  = (a > b);
      m_et  = (a == b);
      m_sgt = ($signed(a) > $signed(b));
      m_set = (a == b);
    end
    e.tag = tag; e.res = er; e.err = ee;
    e.lat = (o == MUL || o == DIV || o == MOD) ? W + 1 : 1;
    e.acc_cyc = cyc;
    e.gt = m_gt; e.et = m_et; e.sgt = m_sgt; e.set = m_set;
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op       = 13'($urandom);
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
    if (hold > 0) begin
      n = 0;
      while (!out_valid && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      for (int i = 0; i < hold; i++) begin
        @(posedge clk);
        #1;
        chk({tag, "_hold_result"}, 32'(result), 32'(er));
        chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({tag, "_drain_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
      lat_seen = 0;
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [12:0] ops [5];
    logic [W-1:0] ra, rb;
    logic [12:0]  ro;
    bit           ov_seen;
    ops[0] = ADD; ops[1] = SUB; ops[2] = MUL; ops[3] = DIV; ops[4] = MOD;

    rst = 1'b1; in_valid = 1'b0; op = '0; op_a = '0; op_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_flag_gt", 32'(flag_gt), 32'd0);
    chk("rst_flag_et", 32'(flag_et), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_wrap", ADD, 16'hFFFF, 16'h0002, 16'h0001, 1'b0, 0);
    run_op("sub_wrap", SUB, 16'h0003, 16'h0005, 16'hFFFE, 1'b0, 0);
    run_op("mul_1",    MUL, 16'h0123, 16'h0010, 16'h1230, 1'b0, 0);
    run_op("mul_ff",   MUL, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op("div_100_7", DIV, 16'd100, 16'd7, 16'h000E, 1'b0, 0);
    run_op("mod_100_7", MOD, 16'd100, 16'd7, 16'h0002, 1'b0, 0);
    run_op("div_by0",  DIV, 16'd5, 16'd0, 16'hFFFF, 1'b1, 0);
    run_op("mod_by0",  MOD, 16'd5, 16'd0, 16'h0005, 1'b1, 0);
    run_op("cmp_8000_1", CMP, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 0);
    run_op("add_keeps_flags", ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0, 0);
    run_op("cmp_5_5",  CMP, 16'd5, 16'd5, 16'h0000, 1'b0, 0);
    run_op("asr",      ASR, 16'h8000, 16'h0013, 16'hF000, 1'b0, 0);
    run_op("lsr",      LSR, 16'h8000, 16'h0013, 16'h1000, 1'b0, 0);
    run_op("lsl",      LSL, 16'h0001, 16'd15, 16'h8000, 1'b0, 0);
    run_op("or",       OR_, 16'h00F0, 16'h0F0F, 16'h0FFF, 1'b0, 0);
    run_op("and",      AND, 16'h0FF0, 16'h3C3C, 16'h0C30, 1'b0, 0);
    run_op("not",      NOT, 16'h1234, 16'h0000, 16'hEDCB, 1'b0, 0);
    run_op("mov",      MOV, 16'h1234, 16'hBEEF, 16'hBEEF, 1'b0, 0);
    run_op("illegal_2bit", 13'b0000000000011, 16'h1111, 16'h2222, 16'h0000, 1'b1, 0);
    run_op("illegal_zero", 13'b0, 16'h1111, 16'h2222, 16'h0000, 1'b1, 0);
    run_op("cmp_gt",   CMP, 16'h0009, 16'h0002, 16'h0007, 1'b0, 0);
    run_op("backpressure", OR_, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 5);

    for (int i = 0; i < 8; i++) begin
      ro = ops[$urandom_range(0, 4)];
      ra = W'($urandom);
      rb = (i == 3) ? '0 : W'($urandom_range(0, 300));
      run_op("rand", ro, ra, rb, ref_res(ro, ra, rb),
             ((ro == DIV || ro == MOD) && rb == 0), 0);
    end

    // Set ET, then abort a division mid-iteration with reset
    run_op("cmp_pre_abort", CMP, 16'd7, 16'd7, 16'h0000, 1'b0, 0);
    wait_ready();
    in_valid = 1'b1; op = DIV; op_a = 16'd100; op_b = 16'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_gt = 1'b0; m_et = 1'b0; m_sgt = 1'b0; m_set = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_flag_gt", 32'(flag_gt), 32'd0);
    chk("abort_flag_et", 32'(flag_et), 32'd0);
    ov_seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) ov_seen = 1;
    end
    chk("abort_no_result", 32'(ov_seen), 32'd0);

    run_op("post_abort_add", ADD, 16'h1000, 16'h0234, 16'h1234, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
